// File: rtl/game_phase_sequencer.sv
// Bricks game flow controller: sequences title, countdown, play and message phases,
// drives the countdown delay block handshake and tracks remaining lives.
module game_phase_sequencer #(
  parameter logic [2:0]  LIVES    = 3'd3,
  parameter logic [25:0] MSG_TIME = 26'd50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startKey,
  input  logic       delayDone,
  input  logic       ballLost,
  input  logic       bricksCleared,
  output logic [2:0] bgState,
  output logic       delayRstN,
  output logic       delayStart,
  output logic [2:0] livesLeft,
  output logic       gamePlaying
);

  localparam logic [2:0] StTitle     = 3'd0;
  localparam logic [2:0] StCountdown = 3'd2;
  localparam logic [2:0] StPlay      = 3'd3;
  localparam logic [2:0] StLostLife  = 3'd4;
  localparam logic [2:0] StWin       = 3'd5;
  localparam logic [2:0] StGameOver  = 3'd6;

  localparam logic [25:0] MsgLast   = MSG_TIME - 26'd1;
  localparam logic [1:0]  SubRearm  = 2'd0;
  localparam logic [1:0]  SubStart  = 2'd1;
  localparam logic [1:0]  SubArmed  = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [1:0]  sub_q, sub_d;
  logic [25:0] timer_q, timer_d;
  logic        key_q;
  logic        rstn_q, rstn_d;
  logic        start_q, start_d;
  logic        playing_q, playing_d;

  logic key_rise;
  logic msg_done;
  logic armed;
  logic phase_change;
  logic in_msg_next;

  assign key_rise     = startKey & ~key_q;
  assign msg_done     = (timer_q == MsgLast);
  assign armed        = (sub_q == SubArmed);
  assign phase_change = (state_d != state_q);
  assign in_msg_next  = (state_d == StLostLife) || (state_d == StWin) ||
                        (state_d == StGameOver);

  always_comb begin : next_phase
    state_d = state_q;
    lives_d = lives_q;
    case (state_q)
      StTitle: begin
        if (key_rise) begin
          state_d = StCountdown;
          lives_d = LIVES;
        end
      end
      StCountdown: begin
        // A done level left over from the previous round is ignored until re-armed.
        if (armed && delayDone) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (bricksCleared) begin
          state_d = StWin;
        end else if (ballLost) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = StLostLife;
          end else begin
            lives_d = 3'd0;
            state_d = StGameOver;
          end
        end
      end
      StLostLife: begin
        if (msg_done) begin
          state_d = StCountdown;
        end
      end
      StWin, StGameOver: begin
        if (msg_done && key_rise) begin
          state_d = StTitle;
          lives_d = LIVES;
        end
      end
      default: begin
        state_d = StTitle;
        lives_d = LIVES;
      end
    endcase
  end

  // Countdown entry: re-arm the delay block for one cycle, then pulse start, then arm.
  always_comb begin : handshake
    sub_d   = SubRearm;
    rstn_d  = 1'b1;
    start_d = 1'b0;
    if (state_d == StCountdown) begin
      if (phase_change) begin
        sub_d  = SubRearm;
        rstn_d = 1'b0;
      end else if (sub_q == SubRearm) begin
        sub_d   = SubStart;
        start_d = 1'b1;
      end else begin
        sub_d = SubArmed;
      end
    end
  end

  always_comb begin : msg_timer
    timer_d = 26'd0;
    if (in_msg_next && !phase_change) begin
      timer_d = msg_done ? timer_q : timer_q + 26'd1;
    end
  end

  assign playing_d = (state_d == StPlay);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StTitle;
      lives_q   <= LIVES;
      sub_q     <= SubRearm;
      timer_q   <= 26'd0;
      key_q     <= 1'b1;
      rstn_q    <= 1'b0;
      start_q   <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      sub_q     <= sub_d;
      timer_q   <= timer_d;
      key_q     <= startKey;
      rstn_q    <= rstn_d;
      start_q   <= start_d;
      playing_q <= playing_d;
    end
  end

  assign bgState     = state_q;
  assign livesLeft   = lives_q;
  assign delayRstN   = rstn_q;
  assign delayStart  = start_q;
  assign gamePlaying = playing_q;

endmodule
